// File: rtl/dbg_cfg_trace_master_pkg.sv
// Shared definitions for the debug configuration / trace master.
package dbg_cfg_trace_master_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, GAP} wr_state_t;
  localparam int DCP_STROBE_BIT = 31;
  localparam int REGNO_W        = 8;
endpackage

// File: rtl/dbg_trace_fifo.sv
// First-word-fall-through trace FIFO; a push into a full FIFO is allowed
// when a pop frees a slot in the same cycle, otherwise the word is dropped.
module dbg_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  output logic [31:0]   rd_data,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          drop
);
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, push, pop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign pop   = rd_en && !empty;
  assign push  = wr_en && (!full || pop);
  assign drop  = wr_en && full && !pop;
  // Gate the head to zero when empty so reset shows a clean bus.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/dbg_cfg_trace_master.sv
// Host-to-monitor configuration write sequencer plus trace capture FIFO
// and event recorder.
module dbg_cfg_trace_master
  import dbg_cfg_trace_master_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          MRST,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [7:0]    cfg_regno,
  input  logic [30:0]   cfg_data,
  input  logic [1:0]    cfg_sel,
  output logic [31:0]   DCP,
  output logic [1:0]    Sel,
  input  logic [31:0]   TP,
  input  logic          TPE,
  input  logic [7:0]    EV,
  input  logic [31:0]   Val,
  input  logic          rd_en,
  output logic [31:0]   rd_data,
  output logic          rd_empty,
  output logic [AW:0]   fifo_count,
  output logic          ovf,
  input  logic          ovf_clr,
  output logic [7:0]    last_ev,
  output logic [31:0]   last_val,
  output logic [15:0]   ev_count
);
  wr_state_t   state, state_nxt;
  logic [30:0] data_q;
  logic [31:0] dcp_nxt;
  logic        accept, drop;

  assign cfg_ready = (state == IDLE);

  // DCP is loaded from the next state so it lines up with the state itself.
  always_comb begin
    state_nxt = state;
    dcp_nxt   = '0;
    accept    = 1'b0;
    case (state)
      IDLE: if (cfg_valid) begin
        accept    = 1'b1;
        state_nxt = ADDR;
        dcp_nxt[DCP_STROBE_BIT]  = 1'b1;
        dcp_nxt[REGNO_W-1:0]     = cfg_regno;
      end
      ADDR: begin
        state_nxt = DATA;
        dcp_nxt   = {1'b0, data_q};
      end
      DATA:    state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge MRST) begin
    if (MRST) begin
      state  <= IDLE;
      DCP    <= '0;
      Sel    <= '0;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      DCP   <= dcp_nxt;
      if (accept) begin
        data_q <= cfg_data;
        Sel    <= cfg_sel;
      end
    end
  end

  dbg_trace_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk     (clk),
    .rst     (MRST),
    .wr_en   (TPE),
    .wr_data (TP),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (rd_empty),
    .count   (fifo_count),
    .drop    (drop)
  );

  always_ff @(posedge clk or posedge MRST) begin
    if (MRST) begin
      ovf      <= 1'b0;
      last_ev  <= '0;
      last_val <= '0;
      ev_count <= '0;
    end else begin
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (EV != '0) begin
        last_ev  <= EV;
        last_val <= Val;
        if (ev_count != 16'hFFFF) ev_count <= ev_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dbg_cfg_trace_master.sv
// Self-checking bench: directed scenarios plus randomized FIFO/event traffic
// compared against a queue-based reference model.
module tb_dbg_cfg_trace_master;
  logic        clk = 1'b0;
  logic        MRST;
  logic        cfg_valid, cfg_ready;
  logic [7:0]  cfg_regno;
  logic [30:0] cfg_data;
  logic [1:0]  cfg_sel;
  logic [31:0] DCP;
  logic [1:0]  Sel;
  logic [31:0] TP;
  logic        TPE;
  logic [7:0]  EV;
  logic [31:0] Val;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_empty;
  logic [4:0]  fifo_count;
  logic        ovf, ovf_clr;
  logic [7:0]  last_ev;
  logic [31:0] last_val;
  logic [15:0] ev_count;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] q[$];
  logic        m_ovf;
  logic [7:0]  m_ev;
  logic [31:0] m_val;
  int          m_cnt;

  always #5 clk = ~clk;

  dbg_cfg_trace_master #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .MRST(MRST), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_regno(cfg_regno), .cfg_data(cfg_data), .cfg_sel(cfg_sel),
    .DCP(DCP), .Sel(Sel), .TP(TP), .TPE(TPE), .EV(EV), .Val(Val),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
    .fifo_count(fifo_count), .ovf(ovf), .ovf_clr(ovf_clr),
    .last_ev(last_ev), .last_val(last_val), .ev_count(ev_count)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    MRST = 1'b1;
    cycle();
    MRST = 1'b0;
    q.delete();
    m_ovf = 1'b0; m_ev = '0; m_val = '0; m_cnt = 0;
  endtask

  task automatic test_reset();
    MRST = 1'b1; cfg_valid = 0; cfg_regno = 0; cfg_data = 0; cfg_sel = 0;
    TP = 0; TPE = 0; EV = 0; Val = 0; rd_en = 0; ovf_clr = 0;
    #3;
    total++;
    if (DCP !== 32'h0 || Sel !== 2'd0 || rd_empty !== 1'b1 || fifo_count !== 5'd0 ||
        ovf !== 1'b0 || last_ev !== 8'd0 || last_val !== 32'd0 || ev_count !== 16'd0 ||
        cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset: DCP=%h Sel=%0d empty=%b cnt=%0d ovf=%b lev=%0d lval=%h evc=%0d rdy=%b",
               DCP, Sel, rd_empty, fifo_count, ovf, last_ev, last_val, ev_count, cfg_ready);
    end
    cycle();
    cycle();
    MRST = 1'b0;
    q.delete();
    m_ovf = 1'b0; m_ev = '0; m_val = '0; m_cnt = 0;
  endtask

  task automatic do_write(input logic [7:0] r, input logic [30:0] d, input logic [1:0] s);
    logic [31:0] exp_addr;
    exp_addr = 32'h8000_0000 | {24'h0, r};
    total++;
    if (cfg_ready !== 1'b1) begin
      bad++; $display("FAIL wr_ready_idle: got %b want 1", cfg_ready);
    end
    cfg_valid = 1'b1; cfg_regno = r; cfg_data = d; cfg_sel = s;
    cycle();
    cfg_valid = 1'b0; cfg_regno = $urandom; cfg_data = $urandom; cfg_sel = $urandom;
    total++;
    if (DCP !== exp_addr || Sel !== s || cfg_ready !== 1'b0) begin
      bad++; $display("FAIL wr_addr: DCP=%h Sel=%0d rdy=%b want %h %0d 0", DCP, Sel, cfg_ready, exp_addr, s);
    end
    cycle();
    total++;
    if (DCP !== {1'b0, d} || cfg_ready !== 1'b0) begin
      bad++; $display("FAIL wr_data: DCP=%h rdy=%b want %h 0", DCP, cfg_ready, {1'b0, d});
    end
    cycle();
    total++;
    if (DCP !== 32'h0 || cfg_ready !== 1'b0) begin
      bad++; $display("FAIL wr_gap: DCP=%h rdy=%b want 0 0", DCP, cfg_ready);
    end
    cycle();
    total++;
    if (DCP !== 32'h0 || cfg_ready !== 1'b1 || Sel !== s) begin
      bad++; $display("FAIL wr_done: DCP=%h rdy=%b Sel=%0d want 0 1 %0d", DCP, cfg_ready, Sel, s);
    end
  endtask

  task automatic test_cfg_write();
    do_write(8'd16, 31'd1, 2'd3);
    for (int i = 0; i < 5; i++)
      do_write(8'($urandom), 31'($urandom), 2'($urandom));
  endtask

  task automatic test_fifo_overflow();
    for (int i = 1; i <= 17; i++) begin
      TPE = 1'b1; TP = i; cycle();
    end
    TPE = 1'b0;
    total++;
    if (fifo_count !== 5'd16 || ovf !== 1'b1) begin
      bad++; $display("FAIL ovf_fill: cnt=%0d ovf=%b want 16 1", fifo_count, ovf);
    end
    for (int i = 1; i <= 16; i++) begin
      total++;
      if (rd_data !== 32'(i) || rd_empty !== 1'b0) begin
        bad++; $display("FAIL ovf_read%0d: got %h empty=%b want %h", i, rd_data, rd_empty, i);
      end
      rd_en = 1'b1; cycle();
    end
    cycle();
    total++;
    if (rd_empty !== 1'b1 || fifo_count !== 5'd0) begin
      bad++; $display("FAIL rd_on_empty: empty=%b cnt=%0d want 1 0", rd_empty, fifo_count);
    end
    rd_en = 1'b0;
    ovf_clr = 1'b1; cycle(); ovf_clr = 1'b0;
    total++;
    if (ovf !== 1'b0) begin
      bad++; $display("FAIL ovf_clear: got %b want 0", ovf);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 1; i <= 16; i++) begin
      TPE = 1'b1; TP = 100 + i; cycle();
    end
    TP = 32'hABCD; rd_en = 1'b1; cycle();
    TPE = 1'b0; rd_en = 1'b0;
    total++;
    if (fifo_count !== 5'd16 || ovf !== 1'b0) begin
      bad++; $display("FAIL full_pushpop: cnt=%0d ovf=%b want 16 0", fifo_count, ovf);
    end
    for (int i = 0; i < 16; i++) begin
      logic [31:0] exp;
      exp = (i == 15) ? 32'hABCD : 32'(102 + i);
      total++;
      if (rd_data !== exp) begin
        bad++; $display("FAIL full_pushpop_read%0d: got %h want %h", i, rd_data, exp);
      end
      rd_en = 1'b1; cycle();
    end
    rd_en = 1'b0;
  endtask

  task automatic test_ovf_clr();
    for (int i = 0; i < 16; i++) begin
      TPE = 1'b1; TP = $urandom; cycle();
    end
    ovf_clr = 1'b1; cycle();
    TPE = 1'b0; ovf_clr = 1'b0;
    total++;
    if (ovf !== 1'b1 || fifo_count !== 5'd16) begin
      bad++; $display("FAIL ovf_set_wins: ovf=%b cnt=%0d want 1 16", ovf, fifo_count);
    end
    ovf_clr = 1'b1; cycle(); ovf_clr = 1'b0;
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) cycle();
    rd_en = 1'b0;
    total++;
    if (ovf !== 1'b0 || rd_empty !== 1'b1) begin
      bad++; $display("FAIL ovf_clr_drain: ovf=%b empty=%b want 0 1", ovf, rd_empty);
    end
  endtask

  task automatic test_events();
    pulse_reset();
    EV = 8'd5; Val = 32'h0000FFFF; cycle();
    EV = 8'd0; Val = 32'h1234_5678; cycle(); cycle();
    total++;
    if (last_ev !== 8'd5 || last_val !== 32'h0000FFFF || ev_count !== 16'd1) begin
      bad++; $display("FAIL event_basic: ev=%0d val=%h cnt=%0d want 5 0000ffff 1", last_ev, last_val, ev_count);
    end
    m_ev = 8'd5; m_val = 32'h0000FFFF; m_cnt = 1;
    for (int i = 0; i < 40; i++) begin
      EV  = ($urandom_range(1, 0) == 1) ? 8'($urandom) : 8'd0;
      Val = $urandom;
      if (EV != 0) begin
        m_ev = EV; m_val = Val;
        if (m_cnt < 65535) m_cnt++;
      end
      cycle();
      total++;
      if (last_ev !== m_ev || last_val !== m_val || ev_count !== 16'(m_cnt)) begin
        bad++; $display("FAIL event_rand%0d: ev=%0d val=%h cnt=%0d want %0d %h %0d",
                        i, last_ev, last_val, ev_count, m_ev, m_val, m_cnt);
      end
    end
    EV = 8'd0;
  endtask

  task automatic test_reset_mid_write();
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      TPE = 1'b1; TP = 32'h55 + i; cycle();
    end
    TPE = 1'b0;
    EV = 8'd9; Val = 32'd7; cycle(); EV = 8'd0;
    cfg_valid = 1'b1; cfg_regno = 8'h22; cfg_data = 31'h1357; cfg_sel = 2'd2;
    cycle();
    cfg_valid = 1'b0;
    cycle();
    total++;
    if (DCP !== 32'h0000_1357) begin
      bad++; $display("FAIL mid_write_pre: DCP=%h want 00001357", DCP);
    end
    MRST = 1'b1;
    #1;
    total++;
    if (DCP !== 32'h0 || rd_empty !== 1'b1 || fifo_count !== 5'd0 || cfg_ready !== 1'b1 ||
        Sel !== 2'd0 || ev_count !== 16'd0 || last_ev !== 8'd0) begin
      bad++; $display("FAIL mid_write_rst: DCP=%h empty=%b cnt=%0d rdy=%b Sel=%0d evc=%0d want 0 1 0 1 0 0",
                      DCP, rd_empty, fifo_count, cfg_ready, Sel, ev_count);
    end
    cycle();
    MRST = 1'b0;
    q.delete();
    m_ovf = 1'b0; m_ev = '0; m_val = '0; m_cnt = 0;
    do_write(8'h7F, 31'h7FFF_FFFF, 2'd1);
  endtask

  task automatic test_random_fifo();
    logic t, r, c, pop, full;
    logic [31:0] w;
    pulse_reset();
    for (int i = 0; i < 300; i++) begin
      total++;
      if (fifo_count !== 5'(q.size()) || rd_empty !== (q.size() == 0) || ovf !== m_ovf ||
          (q.size() != 0 && rd_data !== q[0])) begin
        bad++; $display("FAIL rand_fifo%0d: cnt=%0d empty=%b ovf=%b head=%h want %0d %b %b %h",
                        i, fifo_count, rd_empty, ovf, rd_data, q.size(), q.size() == 0, m_ovf,
                        (q.size() != 0) ? q[0] : 32'h0);
      end
      t = ($urandom_range(9, 0) < ((i < 150) ? 7 : 4));
      r = ($urandom_range(9, 0) < ((i < 150) ? 3 : 6));
      c = ($urandom_range(9, 0) == 0);
      w = $urandom;
      TPE = t; rd_en = r; ovf_clr = c; TP = w;
      pop  = r && (q.size() > 0);
      full = (q.size() == 16);
      if (pop) void'(q.pop_front());
      if (t && (!full || pop)) q.push_back(w);
      if (t && full && !pop) m_ovf = 1'b1;
      else if (c)            m_ovf = 1'b0;
      cycle();
    end
    TPE = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cfg_write();
    test_fifo_overflow();
    test_full_push_pop();
    test_ovf_clr();
    test_events();
    test_reset_mid_write();
    test_random_fifo();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dbg_cfg_trace_master.md
DBG_CFG_TRACE_MASTER -- requirements
Module: dbg_cfg_trace_master

Interface
REQ-001 Parameter DEPTH, default 16, trace FIFO depth in words (power of two, at least 2).
REQ-002 Parameter AW, default 4, FIFO address width, equal to log2(DEPTH).
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 MRST  in  1  reset, asynchronous and active-high.
REQ-005 cfg_valid  in  1  host configuration-write request.
REQ-006 cfg_ready  out  1  write accepted when high together with cfg_valid.
REQ-007 cfg_regno  in  8  target configuration register number.
REQ-008 cfg_data  in  31  register value; bit 31 of the register is always written 0.
REQ-009 cfg_sel  in  2  debug selector forwarded to the monitor.
REQ-010 DCP  out  32  debug configuration port to the monitor.
REQ-011 Sel  out  2  selector to the monitor.
REQ-012 TP  in  32  trace word from the monitor.
REQ-013 TPE  in  1  trace word valid.
REQ-014 EV  in  8  monitor event code; 0 means no event.
REQ-015 Val  in  32  event value.
REQ-016 rd_en  in  1  pop trace FIFO.
REQ-017 rd_data  out  32  FIFO head, first-word-fall-through.
REQ-018 rd_empty  out  1  FIFO empty.
REQ-019 fifo_count  out  AW+1  FIFO occupancy.
REQ-020 ovf  out  1  sticky trace-drop flag.
REQ-021 ovf_clr  in  1  clears ovf.
REQ-022 last_ev  out  8  most recent nonzero EV.
REQ-023 last_val  out  32  Val captured with last_ev.
REQ-024 ev_count  out  16  saturating count of nonzero EV cycles.

Function
REQ-025 The write FSM SHALL use states IDLE, ADDR, DATA and GAP, with cfg_ready high only in IDLE.
REQ-026 In IDLE, when cfg_valid is high, the FSM SHALL latch regno, data and sel and move to ADDR.
REQ-027 In ADDR, the block SHALL register DCP to {1'b1, 23'b0, regno} and Sel to the latched sel.
REQ-028 In DATA, the block SHALL register DCP to {1'b0, data}.
REQ-029 In GAP, DCP SHALL be 0; the FSM then returns to IDLE.
REQ-030 Sel SHALL hold its last value from ADDR until the next write; throughput is one write per 4 cycles.
REQ-031 In IDLE, DCP SHALL be 0.
REQ-032 A TPE-high cycle SHALL push TP when the FIFO is not full, or when it is full and rd_en pops in the same cycle.
REQ-033 Otherwise a TPE-high cycle on a full FIFO SHALL drop the word and set ovf.
REQ-034 rd_en SHALL be ignored while rd_empty is high.
REQ-035 A simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-036 Read and write pointers SHALL wrap modulo DEPTH.
REQ-037 ovf SHALL be cleared by ovf_clr; if a set and a clear occur in the same cycle, the set SHALL win.
REQ-038 When EV is nonzero, last_ev and last_val SHALL register EV and Val, and ev_count SHALL increment, saturating at 16'hFFFF.

Reset
REQ-039 While MRST is high, all registered outputs SHALL be 0 and rd_empty SHALL be 1, asynchronously.
REQ-040 Asserting MRST mid-write SHALL abort the write and return the FSM to IDLE.
REQ-041 Asserting MRST SHALL empty the FIFO; FIFO memory contents need not be reset.

Structure
REQ-042 A shared package SHALL hold the FSM state encoding, the DCP strobe bit index (31), and the register-number field width (8).
REQ-043 The FIFO SHALL be a single sub-module, dbg_trace_fifo, parameterised by DEPTH and AW.

Verification
REQ-044 Write regno=16, data=1, sel=3 -> DCP is 0x80000010, then 0x00000001, then 0 on consecutive cycles; Sel=3; cfg_ready high again on the 4th cycle.
REQ-045 Push 17 TPE words with no reads -> fifo_count=16, ovf=1; reads return words 1..16 in order, then rd_empty=1.
REQ-046 Full FIFO with TPE and rd_en in the same cycle -> fifo_count stays 16, ovf stays 0, the new word is read last.
REQ-047 EV=5, Val=0x0000FFFF for one cycle -> last_ev=5, last_val=0x0000FFFF, ev_count=1; EV=0 afterwards leaves them unchanged.
REQ-048 MRST asserted in DATA with 3 words queued -> DCP=0 immediately, rd_empty=1, fifo_count=0, FSM back in IDLE.
REQ-049 ovf_clr coinciding with a dropped push -> ovf remains 1.
